// File: rtl/mac_operand_packer.sv
// mac_operand_packer: serialises pixel/weight byte streams into LANES-wide MAC operand vectors.
// Optional MAC_SUM_CAPTURE_EN adds a latency-matched capture of the MAC sum.
module mac_operand_packer #(
    parameter int LANES       = 16,
    parameter int PIX_W       = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [PIX_W-1:0]       wt_in,
    input  logic                   wt_valid,
    output logic                   wt_ready,
    output logic [LANES*PIX_W-1:0] pixels_out,
    output logic [LANES*PIX_W-1:0] weights_out,
    output logic                   vec_valid,
    input  logic                   vec_ready,
`ifdef MAC_SUM_CAPTURE_EN
    input  logic [19:0]            sum_in,
    output logic [19:0]            res_out,
    output logic                   res_valid,
`endif
    output logic [15:0]            vec_count
);
    localparam int VW = LANES * PIX_W;
    localparam int CW = $clog2(LANES);
    typedef enum logic [1:0] {WAIT_W, FILL, HOLD} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d, wcnt_q, wcnt_d;
    logic          wfull_q, wfull_d;
    logic [VW-1:0] wsh_q, wsh_d, pix_q, pix_d, wt_q, wt_d;
    logic [15:0]   vcnt_q, vcnt_d;
    logic          hs, wacc, pacc, wlast, plast, commit;
    int            widx, pidx;
    always_comb begin
        hs     = (state_q == HOLD) && vec_ready;
        wacc   = wt_valid && !wfull_q;
        pacc   = pix_valid && (state_q == FILL);
        wlast  = wacc && (wcnt_q == CW'(LANES - 1));
        plast  = pacc && (pcnt_q == CW'(LANES - 1));
        widx   = VW - 1 - PIX_W * int'(wcnt_q);
        pidx   = VW - 1 - PIX_W * int'(pcnt_q);
        wsh_d  = wsh_q;
        pix_d  = pix_q;
        if (wacc) wsh_d[widx -: PIX_W] = wt_in;
        if (pacc) pix_d[pidx -: PIX_W] = pix_in;
        // In HOLD the bank may only swap on the handshake edge, including a bank completing on that edge
        commit  = (state_q == HOLD) ? hs && (wfull_q || wlast) : wfull_q;
        wcnt_d  = (commit || wlast) ? '0 : wacc ? wcnt_q + CW'(1) : wcnt_q;
        wfull_d = commit ? 1'b0 : wfull_q | wlast;
        wt_d    = commit ? wsh_d : wt_q;
        pcnt_d  = (plast || hs) ? '0 : pacc ? pcnt_q + CW'(1) : pcnt_q;
        vcnt_d  = vcnt_q + 16'(hs);
        state_d = (state_q == WAIT_W && commit) ? FILL :
                  plast ? HOLD :
                  hs ? FILL : state_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_W;
            pcnt_q  <= '0;
            wcnt_q  <= '0;
            wfull_q <= 1'b0;
            wsh_q   <= '0;
            pix_q   <= '0;
            wt_q    <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            wcnt_q  <= wcnt_d;
            wfull_q <= wfull_d;
            wsh_q   <= wsh_d;
            pix_q   <= pix_d;
            wt_q    <= wt_d;
            vcnt_q  <= vcnt_d;
        end
    end
    assign pix_ready   = (state_q == FILL);
    assign wt_ready    = !wfull_q;
    assign vec_valid   = (state_q == HOLD);
    assign pixels_out  = pix_q;
    assign weights_out = wt_q;
    assign vec_count   = vcnt_q;
`ifdef MAC_SUM_CAPTURE_EN
    logic [MAC_LATENCY-1:0] hs_sr_q, hs_sr_d;
    logic [19:0]            res_q, res_d;
    logic                   res_valid_q, res_valid_d;
    always_comb begin
        hs_sr_d     = MAC_LATENCY'({hs_sr_q, hs});
        res_valid_d = hs_sr_q[MAC_LATENCY-1];
        res_d       = res_valid_d ? sum_in : res_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_sr_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            hs_sr_q     <= hs_sr_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end
    assign res_out   = res_q;
    assign res_valid = res_valid_q;
`endif
endmodule

// File: tb/tb_mac_operand_packer.sv
// tb_mac_operand_packer: directed plan plus random traffic against a byte-queue reference model.
module tb_mac_operand_packer;
    localparam int L   = 16;
    localparam int LAT = 1;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic [7:0]   pix_in = '0, wt_in = '0;
    logic         pix_valid = 1'b0, wt_valid = 1'b0, vec_ready = 1'b0;
    logic         pix_ready, wt_ready, vec_valid;
    logic [127:0] pixels_out, weights_out;
    logic [15:0]  vec_count;
`ifdef MAC_SUM_CAPTURE_EN
    logic [19:0]  sum_in = '0, res_out;
    logic         res_valid;
    bit           hp[$];
    bit           e_rv;
    logic [19:0]  e_res;
`endif
    int n_cmp = 0, n_err = 0;

    mac_operand_packer #(.LANES(L), .PIX_W(8), .MAC_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .wt_in(wt_in), .wt_valid(wt_valid), .wt_ready(wt_ready),
        .pixels_out(pixels_out), .weights_out(weights_out),
        .vec_valid(vec_valid), .vec_ready(vec_ready),
`ifdef MAC_SUM_CAPTURE_EN
        .sum_in(sum_in), .res_out(res_out), .res_valid(res_valid),
`endif
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    logic [7:0]   wq[$], pq[$];
    logic [127:0] act;
    bit           wfull, have, pres;
    logic [15:0]  vc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] v = '0;
        for (int k = 0; k < q.size(); k++) v[127-8*k -: 8] = q[k];
        return v;
    endfunction

    task automatic model_reset();
        wq.delete(); pq.delete();
        act = '0; wfull = 0; have = 0; pres = 0; vc = '0;
`ifdef MAC_SUM_CAPTURE_EN
        hp.delete();
        for (int i = 0; i < LAT; i++) hp.push_back(1'b0);
        e_rv = 0; e_res = '0;
`endif
    endtask

    task automatic model_update();
        bit hs, wacc, pacc, commit;
        hs   = pres && vec_ready;
        wacc = wt_valid && !wfull;
        pacc = pix_valid && have && !pres;
        if (wacc) wq.push_back(wt_in);
        commit = pres ? (hs && wq.size() == L) : wfull;
        if (commit) begin
            act = pack(wq); wq.delete(); wfull = 0; have = 1;
        end else wfull = (wq.size() == L);
        if (hs) begin pres = 0; pq.delete(); vc++; end
        if (pacc) begin
            pq.push_back(pix_in);
            if (pq.size() == L) pres = 1;
        end
`ifdef MAC_SUM_CAPTURE_EN
        e_rv = hp.pop_front();
        hp.push_back(hs);
        if (e_rv) e_res = sum_in;
`endif
    endtask

    task automatic check_all();
        chk("pix_ready", 128'(pix_ready), 128'(have && !pres));
        chk("wt_ready", 128'(wt_ready), 128'(!wfull));
        chk("vec_valid", 128'(vec_valid), 128'(pres));
        chk("weights_out", weights_out, act);
        chk("vec_count", 128'(vec_count), 128'(vc));
        if (pres) chk("pixels_out", pixels_out, pack(pq));
`ifdef MAC_SUM_CAPTURE_EN
        chk("res_valid", 128'(res_valid), 128'(e_rv));
        chk("res_out", 128'(res_out), 128'(e_res));
`endif
    endtask

    task automatic step(input bit pv, input logic [7:0] pb, input bit wv, input logic [7:0] wb, input bit vr);
        pix_valid = pv; pix_in = pb; wt_valid = wv; wt_in = wb; vec_ready = vr;
`ifdef MAC_SUM_CAPTURE_EN
        sum_in = 20'($urandom);
`endif
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        // first bank 01..10, then one cycle for the commit
        for (int k = 0; k < L; k++) step(0, '0, 1, 8'(k + 1), 0);
        chk("bank0_pre", weights_out, '0);
        step(0, '0, 0, '0, 0);
        chk("bank0", weights_out, 128'h0102030405060708090a0b0c0d0e0f10);
        chk("pix_ready_up", 128'(pix_ready), 128'd1);
        for (int k = 0; k < L; k++) step(1, 8'(8'hA0 + k), 0, '0, 1);
        chk("vec0_pixels", pixels_out, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        chk("vec0_ready_low", 128'(pix_ready), 128'd0);
        step(0, '0, 0, '0, 1);
        chk("vec0_count", 128'(vec_count), 128'd1);
        chk("vec0_valid_drop", 128'(vec_valid), 128'd0);
        // fill a vector while streaming 15 bytes of a new bank, then stall
        for (int k = 0; k < L; k++) step(1, 8'(8'hB0 + k), k < L - 1, 8'h02, 0);
        for (int k = 0; k < 5; k++) step(1, 8'hC0, 0, '0, 0);
        chk("stall_pixels", pixels_out, 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
        chk("stall_old_bank", weights_out, 128'h0102030405060708090a0b0c0d0e0f10);
        step(1, 8'hC0, 1, 8'h02, 1);
        chk("bank1", weights_out, {16{8'h02}});
        for (int k = 0; k < 7; k++) step(1, 8'(8'hC0 + k), 0, '0, 0);
        // asynchronous reset in the middle of a partial vector
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pixels", pixels_out, '0);
        chk("rst_weights", weights_out, '0);
        chk("rst_vec_valid", 128'(vec_valid), '0);
        chk("rst_count", 128'(vec_count), '0);
        chk("rst_pix_ready", 128'(pix_ready), '0);
        chk("rst_wt_ready", 128'(wt_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1, 8'hEE, 0, '0, 1);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 9) < 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_operand_packer.md
Name: mac_operand_packer

Overview:
- Producer end of the 16-lane MAC operand interface.
- Serialises an 8-bit pixel byte stream and an 8-bit weight byte stream into 128-bit pixel and weight vectors, packed lane 0 at MSB, and presents them to the MAC array with a valid/ready handshake.
- Holds a reusable weight bank, so one kernel serves many pixel windows.
- Optionally re-times the MAC's 20-bit sum back into a valid-tagged result stream.

Parameters:
- LANES, 16, bytes per vector; must be ≥2.
- PIX_W, 8, bits per pixel/weight lane.
- MAC_LATENCY, 1, clocks from vector handshake to sum valid at sum_in; range 1–4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pix_in  input  PIX_W  pixel byte
- pix_valid  input  1  pix_in valid
- pix_ready  output  1  packer accepts pix_in this cycle
- wt_in  input  PIX_W  weight byte
- wt_valid  input  1  wt_in valid
- wt_ready  output  1  packer accepts wt_in this cycle
- pixels_out  output  LANES*PIX_W  packed pixel vector, lane 0 = MSBs
- weights_out  output  LANES*PIX_W  active weight bank, lane 0 = MSBs
- vec_valid  output  1  vector presented
- vec_ready  input  1  MAC consumes vector
- vec_count  output  16  vectors issued since reset; wraps

Behaviour:
- Reset (async, rst_n=0): state=WAIT_W; pixel and weight counts 0; shadow bank valid flag 0; pixels_out, weights_out, vec_valid, vec_count, pix_ready all 0. wt_ready=1 out of reset.
- Byte order: k-th accepted byte (k=0..LANES-1) lands in bits [LANES*PIX_W-1-PIX_W*k : LANES*PIX_W-PIX_W*(k+1)].
- Weight path:
  - wt_ready=1 except when the shadow bank is full and not yet committed.
  - Accepted bytes fill a shadow bank; on the LANES-th byte the shadow bank is marked full.
  - Commit shadow→weights_out happens on any cycle with state≠HOLD and shadow full, or on a HOLD handshake cycle. Commit clears the full flag and the count.
  - weights_out never changes while vec_valid=1 without a handshake.
- States:
  - WAIT_W: pix_ready=0. On commit → FILL.
  - FILL: pix_ready=1. On each accepted byte the count increments. On the LANES-th byte → HOLD and vec_valid=1 next cycle.
  - HOLD: pix_ready=0; pixels_out and weights_out stable. On vec_valid&vec_ready: vec_valid=0, count=0, vec_count+1 (wraps at 0xFFFF→0), → FILL.
- Throughput: one bubble per vector, i.e. LANES+1 cycles per vector at full input rate.
- Simultaneous events:
  - Weight byte and pixel byte in the same cycle are both accepted.
  - If the LANES-th weight byte and a HOLD handshake coincide, the commit takes effect on that edge, so the next vector uses the new bank.
- Partial vector: pixel count persists indefinitely; there is no timeout.
- Mid-operation reset discards the partial vector and the weight bank; the block returns to WAIT_W.

Optional Feature:
- Macro: MAC_SUM_CAPTURE_EN.
- When defined, three extra ports are added:
  - sum_in  input  20  MAC sum.
  - res_out  output  20  captured sum.
  - res_valid  output  1  one-cycle pulse.
- A MAC_LATENCY-deep shift register of handshake flags is maintained, reset to 0. When the flag exits, res_out<=sum_in and res_valid=1 for one cycle. res_out holds its value between pulses and resets to 0.
- Back-to-back handshakes produce back-to-back pulses.
- When undefined, the ports and shift register are absent and behaviour is otherwise identical.

Test Plan:
- Reset then 16 weight bytes 0x01..0x10 → weights_out=0x0102…10 one cycle after the 16th byte; pix_ready rises the same cycle.
- Pixel bytes 0xA0..0xAF with vec_ready=1 → vec_valid high exactly one cycle, pixels_out=0xA0A1…AF, vec_count=1, pix_ready low that cycle.
- Hold vec_ready=0 for 5 cycles with pix_valid=1 → pixels_out stable, pix_ready=0 for all 5 cycles, no byte lost. Release → next vector begins with the pending byte.
- Load new weight bank (all 0x02) during HOLD, completing on the handshake cycle → the following vector presents weights_out=0x0202…02 and the previous vector still saw the old bank.
- Assert rst_n=0 after 7 pixel bytes → all outputs 0 immediately (async), state WAIT_W, pix_ready=0 until a new bank is loaded.
- With MAC_SUM_CAPTURE_EN and MAC_LATENCY=1: drive sum_in=0x12345 one cycle after the handshake → res_valid pulse and res_out=0x12345. Two consecutive vectors produce two consecutive pulses.
